hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have port: CLOCK  in  1  pipeline clock, all state on rising edge.
REQ-002 SHALL have port: RESET  in  1  asynchronous, active-low reset (0 = reset).
REQ-003 SHALL have port: RsD, RtD  in  5 each  source registers of the instruction in ID.
REQ-004 SHALL have port: RsE, RtE  in  5 each  source registers of the instruction in EX.
REQ-005 SHALL have port: WriteRegE, WriteRegM, WriteRegW  in  5 each  destination register per stage.
REQ-006 SHALL have port: RegWriteE, RegWriteM, RegWriteW  in  1 each  destination write enable per stage.
REQ-007 SHALL have port: MemtoRegE, MemtoRegM  in  1 each  load instruction in EX / MEM.
REQ-008 SHALL have port: BranchD  in  1  branch in ID.
REQ-009 SHALL have port: PCSrcD  in  1  branch in ID resolved taken.
REQ-010 SHALL have port: StallF, StallD  out  1 each  hold PC / IF_ID register.
REQ-011 SHALL have port: FlushD  out  1  clear IF_ID register.
REQ-012 SHALL have port: FlushE  out  1  load bubble into ID_EX register.
REQ-013 SHALL have port: ForwardAE, ForwardBE  out  2 each  EX operand select (00 reg file, 01 WB, 10 MEM).
REQ-014 SHALL have port: ForwardAD, ForwardBD  out  1 each  ID branch comparator takes MEM result.
REQ-015 SHALL have port: HazErr  out  1  sticky error, stall exceeded limit.

Function
REQ-016 Register 0 SHALL never match for forwarding or hazard detection.
REQ-017 ForwardAE SHALL be 10 if RegWriteM and WriteRegM==RsE, else 01 if RegWriteW and WriteRegW==RsE, else 00; MEM wins on a double match; ForwardBE is the same with RtE.
REQ-018 ForwardAD/BD SHALL be 1 iff RegWriteM and WriteRegM equals RsD/RtD.
REQ-019 lwstall SHALL equal MemtoRegE and RtE equal to RsD or RtD.
REQ-020 brstall SHALL equal BranchD and either (RegWriteE and WriteRegE in {RsD,RtD}) or (MemtoRegM and WriteRegM in {RsD,RtD}).
REQ-021 StallF, StallD and FlushE SHALL equal lwstall or brstall in the same cycle (combinational, zero latency).
REQ-022 FlushD SHALL equal PCSrcD and not (lwstall or brstall); a stall takes precedence over a flush.
REQ-023 FSM states SHALL be RUN, STALL, FLUSH, ERR; transitions on each CLOCK edge:
REQ-024 RUN: to STALL on a stall, else to FLUSH on FlushD, else stay in RUN.
REQ-025 STALL: increment a 2-bit consecutive-stall count; return to RUN/FLUSH per REQ-024 when the stall clears; go to ERR when a third consecutive stall cycle would be entered.
REQ-026 FLUSH SHALL last exactly one cycle and then re-evaluate per REQ-024.
REQ-027 ERR SHALL set HazErr, hold it until reset, and keep REQ-017..022 outputs functional.

Reset
REQ-028 While RESET=0: state RUN, stall count 0, HazErr 0, and all Stall/Flush/Forward outputs forced to 0, asynchronously.
REQ-029 On RESET release, the first rising edge SHALL evaluate from RUN; a reset during STALL abandons the stall.

Configuration
REQ-030 With HAZARD_STATS_EN defined, the block SHALL add outputs StallCnt[15:0] and FlushCnt[15:0], counting stall and FlushD cycles, saturating at 0xFFFF, cleared by reset; without the macro, the ports and logic SHALL be absent.

Structure
REQ-031 The FSM state enum, the forward-select codes (FWD_RF=00, FWD_WB=01, FWD_MEM=10) and STALL_LIMIT=2 SHALL live in the shared pipeline package.
REQ-032 Forwarding compare SHALL be one sub-module, fwd_unit, instantiated once for the EX operands and once for the ID operands.

Verification
REQ-033 lw $2 in EX, ID reads RsD=2 -> StallF=StallD=FlushE=1 for 1 cycle; next cycle ForwardAE=10.
REQ-034 RegWriteM with WriteRegM=5 and RegWriteW with WriteRegW=5, RsE=5 -> ForwardAE=10 (MEM priority); WriteRegM=0, RsE=0 -> 00.
REQ-035 beq in ID on $3, lw $3 in EX -> 2 stall cycles, then ForwardAD=1, PCSrcD=1 -> FlushD=1 for exactly 1 cycle.
REQ-036 Stall held for 3 consecutive cycles by force -> HazErr=1 and sticky; RESET pulse low -> HazErr=0 immediately.
REQ-037 RESET asserted mid-stall -> all outputs 0 asynchronously; with HAZARD_STATS_EN, StallCnt=0 and saturation at 0xFFFF is checked.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline package for the hazard controller.
// Holds the hazard FSM state type, the EX operand forward-select codes,
// the consecutive-stall limit and a register-match helper.
package hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN,
      STALL,
      FLUSH,
      ERR
   } haz_state_t;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   // Stall cycles tolerated back to back; one more is an error.
   localparam int unsigned STALL_LIMIT = 2;

   // $0 is hardwired to zero, so it never creates a dependency.
   function automatic logic reg_hit(input logic [4:0] a, input logic [4:0] b);
      return (a != '0) && (a == b);
   endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// fwd_unit: forwarding compare for one pair of source operands.
// Ports:
//   rs, rt       source registers of the consuming instruction
//   wr_m, we_m   MEM-stage destination register / write enable
//   wr_w, we_w   WB-stage destination register / write enable
//   fwd_a, fwd_b operand select (FWD_RF, FWD_WB, FWD_MEM); MEM has priority
module fwd_unit
   import hazard_ctrl_pkg::*;
(
   input  logic [4:0] rs,
   input  logic [4:0] rt,
   input  logic [4:0] wr_m,
   input  logic       we_m,
   input  logic [4:0] wr_w,
   input  logic       we_w,
   output logic [1:0] fwd_a,
   output logic [1:0] fwd_b
);

   function automatic logic [1:0] sel(input logic [4:0] src,
                                      input logic [4:0] rm, input logic em,
                                      input logic [4:0] rw, input logic ew);
      if (em && reg_hit(rm, src))
         return FWD_MEM;
      else if (ew && reg_hit(rw, src))
         return FWD_WB;
      else
         return FWD_RF;
   endfunction

   always_comb begin
      fwd_a = sel(rs, wr_m, we_m, wr_w, we_w);
      fwd_b = sel(rt, wr_m, we_m, wr_w, we_w);
   end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard unit (load-use / branch stalls, IF flush,
// EX and ID forwarding) with a stall-watchdog FSM.
// Ports:
//   CLOCK, RESET                 clock, async active-low reset
//   RsD/RtD, RsE/RtE             ID / EX source registers
//   WriteReg{E,M,W}, RegWrite{E,M,W}, MemtoReg{E,M}  per-stage destination info
//   BranchD, PCSrcD              branch in ID / branch taken
//   StallF, StallD, FlushE       asserted on lwstall or brstall
//   FlushD                       taken branch with no stall
//   ForwardAE/BE, ForwardAD/BD   forwarding selects
//   HazErr                       sticky: third consecutive stall cycle seen
// Optional: HAZARD_STATS_EN adds StallCnt/FlushCnt saturating counters.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
(
   input  logic       CLOCK,
   input  logic       RESET,
   input  logic [4:0] RsD,
   input  logic [4:0] RtD,
   input  logic [4:0] RsE,
   input  logic [4:0] RtE,
   input  logic [4:0] WriteRegE,
   input  logic [4:0] WriteRegM,
   input  logic [4:0] WriteRegW,
   input  logic       RegWriteE,
   input  logic       RegWriteM,
   input  logic       RegWriteW,
   input  logic       MemtoRegE,
   input  logic       MemtoRegM,
   input  logic       BranchD,
   input  logic       PCSrcD,
   output logic       StallF,
   output logic       StallD,
   output logic       FlushD,
   output logic       FlushE,
   output logic [1:0] ForwardAE,
   output logic [1:0] ForwardBE,
   output logic       ForwardAD,
   output logic       ForwardBD,
`ifdef HAZARD_STATS_EN
   output logic [15:0] StallCnt,
   output logic [15:0] FlushCnt,
`endif
   output logic       HazErr
);

   logic [1:0] fwd_e_a, fwd_e_b, fwd_d_a, fwd_d_b;
   logic       lwstall, brstall, stall, flush_d;
   haz_state_t state;
   logic [1:0] stall_cnt;

   fwd_unit u_fwd_e (
      .rs    (RsE),
      .rt    (RtE),
      .wr_m  (WriteRegM),
      .we_m  (RegWriteM),
      .wr_w  (WriteRegW),
      .we_w  (RegWriteW),
      .fwd_a (fwd_e_a),
      .fwd_b (fwd_e_b)
   );

   // The ID comparator only has a MEM bypass; WB is handled by the
   // register file writing in the first half of the cycle.
   fwd_unit u_fwd_d (
      .rs    (RsD),
      .rt    (RtD),
      .wr_m  (WriteRegM),
      .we_m  (RegWriteM),
      .wr_w  ('0),
      .we_w  (1'b0),
      .fwd_a (fwd_d_a),
      .fwd_b (fwd_d_b)
   );

   always_comb begin
      lwstall = MemtoRegE && (reg_hit(RtE, RsD) || reg_hit(RtE, RtD));
      brstall = BranchD &&
                ((RegWriteE && (reg_hit(WriteRegE, RsD) || reg_hit(WriteRegE, RtD))) ||
                 (MemtoRegM && (reg_hit(WriteRegM, RsD) || reg_hit(WriteRegM, RtD))));
      stall   = lwstall || brstall;
      flush_d = PCSrcD && !stall;
   end

   // Outputs are gated by RESET so they drop to zero asynchronously.
   always_comb begin
      StallF    = RESET && stall;
      StallD    = RESET && stall;
      FlushE    = RESET && stall;
      FlushD    = RESET && flush_d;
      ForwardAE = RESET ? fwd_e_a : FWD_RF;
      ForwardBE = RESET ? fwd_e_b : FWD_RF;
      ForwardAD = RESET && (fwd_d_a == FWD_MEM);
      ForwardBD = RESET && (fwd_d_b == FWD_MEM);
   end

   // stall_cnt holds the number of consecutive stall cycles already taken.
   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         state     <= RUN;
         stall_cnt <= '0;
         HazErr    <= 1'b0;
      end else begin
         case (state)
            RUN, FLUSH: begin
               if (stall) begin
                  state     <= STALL;
                  stall_cnt <= 2'd1;
               end else if (flush_d) begin
                  state     <= FLUSH;
               end else begin
                  state     <= RUN;
               end
            end
            STALL: begin
               if (stall) begin
                  if (stall_cnt >= 2'(STALL_LIMIT)) begin
                     state  <= ERR;
                     HazErr <= 1'b1;
                  end else begin
                     stall_cnt <= stall_cnt + 2'd1;
                  end
               end else begin
                  stall_cnt <= '0;
                  state     <= flush_d ? FLUSH : RUN;
               end
            end
            ERR: begin
               state  <= ERR;
               HazErr <= 1'b1;
            end
            default: state <= RUN;
         endcase
      end
   end

`ifdef HAZARD_STATS_EN
   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         StallCnt <= '0;
         FlushCnt <= '0;
      end else begin
         if (stall && StallCnt != '1)
            StallCnt <= StallCnt + 16'd1;
         if (flush_d && FlushCnt != '1)
            FlushCnt <= FlushCnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

   logic       CLOCK = 1'b0;
   logic       RESET;
   logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
   logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, BranchD, PCSrcD;
   logic       StallF, StallD, FlushD, FlushE, ForwardAD, ForwardBD, HazErr;
   logic [1:0] ForwardAE, ForwardBE;
`ifdef HAZARD_STATS_EN
   logic [15:0] StallCnt, FlushCnt;
   int m_scnt, m_fcnt;
`endif

   int checks = 0;
   int errors = 0;
   int run_len = 0;   // consecutive stall cycles clocked in so far
   bit m_err = 0;

   hazard_ctrl dut (
      .CLOCK(CLOCK), .RESET(RESET),
      .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
      .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
      .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
      .BranchD(BranchD), .PCSrcD(PCSrcD),
      .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
`ifdef HAZARD_STATS_EN
      .StallCnt(StallCnt), .FlushCnt(FlushCnt),
`endif
      .HazErr(HazErr)
   );

   always #5 CLOCK = ~CLOCK;

   // ---------------- reference model ----------------
   function automatic bit dep(input logic [4:0] dst, input logic [4:0] src);
      return dst != 0 && dst == src;
   endfunction

   function automatic int fwd_ex(input logic [4:0] src);
      if (RegWriteM && dep(WriteRegM, src)) return 2;
      if (RegWriteW && dep(WriteRegW, src)) return 1;
      return 0;
   endfunction

   function automatic bit m_stall();
      bit lw, br;
      lw = MemtoRegE && (dep(RtE, RsD) || dep(RtE, RtD));
      br = BranchD && ((RegWriteE && (dep(WriteRegE, RsD) || dep(WriteRegE, RtD))) ||
                       (MemtoRegM && (dep(WriteRegM, RsD) || dep(WriteRegM, RtD))));
      return lw || br;
   endfunction

   task automatic model_reset();
      run_len = 0;
      m_err   = 0;
`ifdef HAZARD_STATS_EN
      m_scnt = 0;
      m_fcnt = 0;
`endif
   endtask

   task automatic model_clock();
      bit s;
      s = m_stall();
      run_len = s ? run_len + 1 : 0;
      if (run_len >= 3) m_err = 1;
`ifdef HAZARD_STATS_EN
      if (s && m_scnt < 65535) m_scnt++;
      if (PCSrcD && !s && m_fcnt < 65535) m_fcnt++;
`endif
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      bit r, s;
      r = (RESET === 1'b1);
      s = r && m_stall();
      chk("StallF", {31'b0, StallF}, {31'b0, s});
      chk("StallD", {31'b0, StallD}, {31'b0, s});
      chk("FlushE", {31'b0, FlushE}, {31'b0, s});
      chk("FlushD", {31'b0, FlushD}, {31'b0, r && PCSrcD && !s});
      chk("ForwardAE", {30'b0, ForwardAE}, r ? fwd_ex(RsE) : 0);
      chk("ForwardBE", {30'b0, ForwardBE}, r ? fwd_ex(RtE) : 0);
      chk("ForwardAD", {31'b0, ForwardAD}, {31'b0, r && RegWriteM && dep(WriteRegM, RsD)});
      chk("ForwardBD", {31'b0, ForwardBD}, {31'b0, r && RegWriteM && dep(WriteRegM, RtD)});
      chk("HazErr", {31'b0, HazErr}, {31'b0, m_err});
`ifdef HAZARD_STATS_EN
      chk("StallCnt", {16'b0, StallCnt}, m_scnt);
      chk("FlushCnt", {16'b0, FlushCnt}, m_fcnt);
`endif
   endtask

   // Inputs already driven: settle, check, clock, advance model.
   task automatic step();
      #1 check_all();
      @(posedge CLOCK);
      if (RESET) model_clock();
      #1;
   endtask

   task automatic idle_inputs();
      {RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW} = '0;
      {RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, BranchD, PCSrcD} = '0;
   endtask

   task automatic pulse_reset();
      RESET = 1'b0;
      model_reset();
      #1 check_all();
      @(negedge CLOCK);
      RESET = 1'b1;
   endtask

   initial begin
      RESET = 1'b0;
      idle_inputs();
      model_reset();
      // Reset state, with inputs that would otherwise stall and forward.
      #2;
      MemtoRegE = 1; RtE = 2; RsD = 2; RegWriteM = 1; WriteRegM = 2; RsE = 2; PCSrcD = 1;
      #1 check_all();
      chk("reset_stall_forced0", {31'b0, StallF}, 0);
      @(negedge CLOCK);
      RESET = 1'b1;
      idle_inputs();
      step();

      // lw $2 in EX, ID reads $2: one stall cycle, then MEM forward.
      MemtoRegE = 1; RegWriteE = 1; WriteRegE = 2; RtE = 2; RsD = 2;
      #1 chk("lwstall_StallF", {31'b0, StallF}, 1);
      step();
      idle_inputs();
      RegWriteM = 1; MemtoRegM = 1; WriteRegM = 2; RsE = 2;
      #1 chk("lw_fwd_AE", {30'b0, ForwardAE}, 2);
      chk("lw_nostall", {31'b0, StallF}, 0);
      step();

      // MEM has priority over WB; $0 never forwards.
      idle_inputs();
      RegWriteM = 1; WriteRegM = 5; RegWriteW = 1; WriteRegW = 5; RsE = 5; RtE = 5;
      #1 chk("mem_priority", {30'b0, ForwardAE}, 2);
      step();
      WriteRegM = 0; WriteRegW = 0; RsE = 0; RtE = 0;
      #1 chk("reg0_nofwd", {30'b0, ForwardAE}, 0);
      step();

      // beq on $3 behind lw $3: two stall cycles, then a one-cycle flush.
      idle_inputs();
      BranchD = 1; RsD = 3; MemtoRegE = 1; RegWriteE = 1; WriteRegE = 3; RtE = 3;
      step();
      MemtoRegE = 0; RegWriteE = 0; WriteRegE = 0; RtE = 0;
      RegWriteM = 1; MemtoRegM = 1; WriteRegM = 3;
      #1 chk("br_stall2", {31'b0, StallD}, 1);
      step();
      MemtoRegM = 0; PCSrcD = 1;
      #1 chk("br_fwdAD", {31'b0, ForwardAD}, 1);
      chk("br_flushD", {31'b0, FlushD}, 1);
      step();
      idle_inputs();
      #1 chk("br_flush_once", {31'b0, FlushD}, 0);
      chk("br_no_err", {31'b0, HazErr}, 0);
      step();

      // Three consecutive stall cycles -> sticky error; reset clears it at once.
      MemtoRegE = 1; RtE = 7; RsD = 7;
      repeat (3) step();
      chk("err_set", {31'b0, HazErr}, 1);
      idle_inputs();
      step();
      chk("err_sticky", {31'b0, HazErr}, 1);
      RegWriteM = 1; WriteRegM = 9; RsE = 9;
      #1 chk("err_fwd_alive", {30'b0, ForwardAE}, 2);
      RESET = 1'b0;
      model_reset();
      #1 chk("err_cleared", {31'b0, HazErr}, 0);
      check_all();
      @(negedge CLOCK);
      RESET = 1'b1;
      idle_inputs();

      // Reset in the middle of a stall: outputs drop asynchronously.
      MemtoRegE = 1; RtE = 4; RtD = 4;
      step();
      RESET = 1'b0;
      model_reset();
      #1 chk("midstall_StallF", {31'b0, StallF}, 0);
      check_all();
      @(negedge CLOCK);
      RESET = 1'b1;
      step();

      // Randomized traffic against the model, with occasional reset pulses.
      for (int i = 0; i < 400; i++) begin
         RsD = 5'($urandom_range(0, 3));  RtD = 5'($urandom_range(0, 3));
         RsE = 5'($urandom_range(0, 3));  RtE = 5'($urandom_range(0, 3));
         WriteRegE = 5'($urandom_range(0, 3));
         WriteRegM = 5'($urandom_range(0, 3));
         WriteRegW = 5'($urandom_range(0, 3));
         RegWriteE = 1'($urandom); RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
         MemtoRegE = ($urandom_range(0, 3) == 0);
         MemtoRegM = ($urandom_range(0, 3) == 0);
         BranchD   = ($urandom_range(0, 3) == 0);
         PCSrcD    = 1'($urandom);
         if ($urandom_range(0, 29) == 0) pulse_reset();
         else step();
      end

`ifdef HAZARD_STATS_EN
      // Counter saturation under a permanent stall.
      idle_inputs();
      MemtoRegE = 1; RtE = 6; RsD = 6;
      repeat (65540) begin
         @(posedge CLOCK);
         model_clock();
      end
      #1 chk("stallcnt_sat", {16'b0, StallCnt}, 32'h0000FFFF);
      check_all();
      RESET = 1'b0;
      model_reset();
      #1 chk("stallcnt_reset", {16'b0, StallCnt}, 0);
      @(negedge CLOCK);
      RESET = 1'b1;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
